// File: rtl/gcd_engine.sv
// GCD by repeated subtraction: operands load in parallel on start, busy covers the
// whole operation, done pulses once, and result/iter_count hold until the next completion.
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] iter_r, iter_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Saturating step counter: stays at all-ones instead of wrapping.
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1));

  // Next-state and datapath update; every register holds unless a state changes it.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    result_s = result_r;
    cnt_s    = cnt_r;
    iter_s   = iter_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_s     = a_in;
          b_s     = b_in;
          cnt_s   = ZERO_C;
          busy_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // A zero operand ends the run with the other operand (gcd(x,0)=x, gcd(0,0)=0).
        if ((a_r == ZERO_W) || (b_r == ZERO_W) || (a_r == b_r)) begin
          result_s = a_r | b_r;
          iter_s   = cnt_r;
          busy_s   = 1'b0;
          done_s   = 1'b1;
          state_s  = DONE;
        end else if (a_r > b_r) begin
          a_s   = a_r - b_r;
          cnt_s = cnt_inc_s;
        end else begin
          b_s   = b_r - a_r;
          cnt_s = cnt_inc_s;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      result_r <= ZERO_W;
      cnt_r    <= ZERO_C;
      iter_r   <= ZERO_C;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      b_r      <= b_s;
      result_r <= result_s;
      cnt_r    <= cnt_s;
      iter_r   <= iter_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign result     = result_r;
  assign iter_count = iter_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: three instances (16/16, 16/8 and 8/8 widths),
// expected results from a Euclid-quotient model, compared when done pulses.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, start8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [15:0] result16, iter16, result16s;
  logic [7:0]  iter16s, result8, iter8;
  logic        busy16, done16, busy16s, done16s, busy8, done8;

  gcd_engine #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a_in(a16), .b_in(b16),
    .result(result16), .iter_count(iter16), .busy(busy16), .done(done16));

  gcd_engine #(.WIDTH(16), .CNT_W(8)) dut16s (
    .clk(clk), .rst(rst), .start(start16), .a_in(a16), .b_in(b16),
    .result(result16s), .iter_count(iter16s), .busy(busy16s), .done(done16s));

  gcd_engine #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .result(result8), .iter_count(iter8), .busy(busy8), .done(done8));

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] it;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done16_cnt = 0;
  int   done8_cnt = 0;

  always @(negedge clk) begin
    if (done16 === 1'b1) done16_cnt++;
    if (done8 === 1'b1) done8_cnt++;
  end

  // gcd by Euclid; subtraction steps = sum of Euclid quotients minus one.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input longint cmax);
    exp_t   e;
    longint x, y, t, qs;
    x = a; y = b; qs = 0;
    if (x == 0 || y == 0) begin
      e.res = a | b;
      e.it  = 16'd0;
      return e;
    end
    while (y != 0) begin
      qs = qs + x / y;
      t  = x % y;
      x  = y;
      y  = t;
    end
    qs = qs - 1;
    if (qs > cmax) qs = cmax;
    e.res = x[15:0];
    e.it  = qs[15:0];
    return e;
  endfunction

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input bit push);
    @(negedge clk);
    a16 = a; b16 = b; start16 = 1'b1;
    if (push) exp_q.push_back(model(a, b, 65535));
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // cycles = edges since the accepting edge, inclusive; done seen after N+2 for N steps.
  task automatic wait_done16(input int c0, output int cycles, output bit timeout, output bit busy_bad);
    cycles = c0; timeout = 1'b0; busy_bad = 1'b0;
    while (done16 !== 1'b1) begin
      if (busy16 !== 1'b1) busy_bad = 1'b1;
      if (cycles >= 70000) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_done8(output int cycles, output bit timeout);
    cycles = 1; timeout = 1'b0;
    while (done8 !== 1'b1) begin
      if (cycles >= 400) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (result16 !== 16'd0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result16); end
    vectors++; if (iter16 !== 16'd0) begin miscompares++; $display("FAIL reset_iter: got %0d expected 0", iter16); end
    vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy16); end
    vectors++; if (done16 !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done16); end
    vectors++; if (result8 !== 8'd0 || busy8 !== 1'b0) begin miscompares++; $display("FAIL reset_dut8: got result %0d busy %b expected 0 0", result8, busy8); end
    rst = 1'b0;
  endtask

  task automatic test_basic_ops();
    logic [15:0] ta [5] = '{16'd143, 16'd48, 16'd0, 16'd25, 16'd0};
    logic [15:0] tv [5] = '{16'd78, 16'd48, 16'd25, 16'd0, 16'd0};
    int          tlat [5] = '{8, 2, 2, 2, 2};
    int cyc; bit to, bb; exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue16(ta[i], tv[i], 1'b1);
      wait_done16(1, cyc, to, bb);
      e = exp_q.pop_front();
      vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout[%0d]: got no done expected done", i); end
      vectors++; if (bb) begin miscompares++; $display("FAIL basic_busy_drop[%0d]: got busy low expected high", i); end
      vectors++; if (cyc !== tlat[i]) begin miscompares++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, cyc, tlat[i]); end
      vectors++; if (busy16 !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done[%0d]: got %b expected 0", i, busy16); end
      vectors++; if (result16 !== e.res) begin miscompares++; $display("FAIL basic_result[%0d]: got %0d expected %0d", i, result16, e.res); end
      vectors++; if (iter16 !== e.it) begin miscompares++; $display("FAIL basic_iter[%0d]: got %0d expected %0d", i, iter16, e.it); end
      @(negedge clk);
      vectors++; if (done16 !== 1'b0) begin miscompares++; $display("FAIL basic_done_width[%0d]: got %b expected 0", i, done16); end
    end
  endtask

  task automatic test_saturation();
    int cyc; bit to, bb; exp_t e, es;
    issue16(16'd65535, 16'd1, 1'b1);
    wait_done16(1, cyc, to, bb);
    e  = exp_q.pop_front();
    es = model(16'd65535, 16'd1, 255);
    vectors++; if (to) begin miscompares++; $display("FAIL sat_timeout: got no done expected done"); end
    vectors++; if (cyc !== 65536) begin miscompares++; $display("FAIL sat_latency: got %0d expected 65536", cyc); end
    vectors++; if (result16 !== e.res || iter16 !== e.it) begin miscompares++; $display("FAIL sat_wide: got %0d/%0d expected %0d/%0d", result16, iter16, e.res, e.it); end
    vectors++; if (result16s !== es.res || iter16s !== es.it[7:0]) begin miscompares++; $display("FAIL sat_narrow: got %0d/%0d expected %0d/%0d", result16s, iter16s, es.res, es.it); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int cyc; bit to, bb; exp_t e;
    issue16(16'd143, 16'd78, 1'b1);
    repeat (2) @(negedge clk);
    a16 = 16'd10; b16 = 16'd4; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_done16(4, cyc, to, bb);
    e = exp_q.pop_front();
    vectors++; if (to || cyc !== 8) begin miscompares++; $display("FAIL ignore_latency: got %0d expected 8", cyc); end
    vectors++; if (result16 !== e.res || iter16 !== e.it) begin miscompares++; $display("FAIL ignore_result: got %0d/%0d expected %0d/%0d", result16, iter16, e.res, e.it); end
    @(negedge clk);
    issue16(16'd10, 16'd4, 1'b1);
    wait_done16(1, cyc, to, bb);
    e = exp_q.pop_front();
    vectors++; if (to || result16 !== e.res || iter16 !== e.it) begin miscompares++; $display("FAIL idle_reissue: got %0d/%0d expected %0d/%0d", result16, iter16, e.res, e.it); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int cyc, d0; bit to, bb; exp_t e;
    d0 = done16_cnt;
    issue16(16'd143, 16'd78, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (busy16 !== 1'b0 || done16 !== 1'b0) begin miscompares++; $display("FAIL abort_flags: got busy %b done %b expected 0 0", busy16, done16); end
    vectors++; if (result16 !== 16'd0 || iter16 !== 16'd0) begin miscompares++; $display("FAIL abort_outputs: got %0d/%0d expected 0/0", result16, iter16); end
    repeat (20) @(negedge clk);
    vectors++; if (done16_cnt !== d0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", done16_cnt - d0); end
    issue16(16'd12, 16'd18, 1'b1);
    wait_done16(1, cyc, to, bb);
    e = exp_q.pop_front();
    vectors++; if (to || result16 !== e.res || iter16 !== e.it) begin miscompares++; $display("FAIL abort_next: got %0d/%0d expected %0d/%0d", result16, iter16, e.res, e.it); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc, d0; bit to; exp_t e;
    d0 = done8_cnt;
    @(negedge clk);
    a8 = 8'd91; b8 = 8'd35; start8 = 1'b1;
    exp_q.push_back(model(16'd91, 16'd35, 255));
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(cyc, to);
    e = exp_q.pop_front();
    vectors++; if (to || result8 !== e.res[7:0] || iter8 !== e.it[7:0]) begin miscompares++; $display("FAIL b2b_first: got %0d/%0d expected %0d/%0d", result8, iter8, e.res, e.it); end
    // Request held from the done cycle: ignored in DONE, accepted once back in IDLE.
    a8 = 8'd200; b8 = 8'd120; start8 = 1'b1;
    exp_q.push_back(model(16'd200, 16'd120, 255));
    @(negedge clk);
    vectors++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin miscompares++; $display("FAIL b2b_done_state: got busy %b done %b expected 0 0", busy8, done8); end
    @(negedge clk);
    vectors++; if (busy8 !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got busy %b expected 1", busy8); end
    start8 = 1'b0;
    wait_done8(cyc, to);
    e = exp_q.pop_front();
    vectors++; if (to || result8 !== e.res[7:0] || iter8 !== e.it[7:0]) begin miscompares++; $display("FAIL b2b_second: got %0d/%0d expected %0d/%0d", result8, iter8, e.res, e.it); end
    repeat (3) @(negedge clk);
    vectors++; if (done8_cnt - d0 !== 2) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 2", done8_cnt - d0); end
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    test_reset();
    test_basic_ops();
    test_saturation();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
